// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with private HI/LO for the EXEC stage.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMfhi  = 3'b100;
    localparam logic [2:0] OpMflo  = 3'b101;
    localparam logic [2:0] OpMthi  = 3'b110;
    localparam logic [2:0] OpMtlo  = 3'b111;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e             state_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   dividend_q;
    logic               is_div_q;
    logic               div_zero_q;
    logic               neg_res_q;
    logic               neg_rem_q;

    logic               accept;
    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = op_valid & ~busy;
    assign stall     = op_valid & busy;
    assign signed_op = ~op[0];
    assign sign_a    = signed_op & rs_data[WIDTH-1];
    assign sign_b    = signed_op & rt_data[WIDTH-1];
    assign mag_a     = sign_a ? -rs_data : rs_data;
    assign mag_b     = sign_b ? -rt_data : rt_data;

    // Multiply: low half of acc holds the remaining multiplier bits, high half the partial sum.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        mf_data = '0;
        if (accept && op == OpMfhi) mf_data = hi;
        if (accept && op == OpMflo) mf_data = lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            count_q    <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (op)
                            OpMult, OpMultu: begin
                                state_q   <= StMul;
                                busy      <= 1'b1;
                                count_q   <= '0;
                                acc_q     <= {{WIDTH{1'b0}}, mag_b};
                                opb_q     <= mag_a;
                                is_div_q  <= 1'b0;
                                neg_res_q <= sign_a ^ sign_b;
                            end
                            OpDiv, OpDivu: begin
                                state_q    <= StDiv;
                                busy       <= 1'b1;
                                count_q    <= '0;
                                acc_q      <= {{WIDTH{1'b0}}, mag_a};
                                opb_q      <= mag_b;
                                dividend_q <= rs_data;
                                is_div_q   <= 1'b1;
                                div_zero_q <= (rt_data == '0);
                                neg_res_q  <= sign_a ^ sign_b;
                                neg_rem_q  <= sign_a;
                            end
                            OpMthi:  hi <= rs_data;
                            OpMtlo:  lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    acc_q   <= mul_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) state_q <= StFix;
                end
                StDiv: begin
                    acc_q   <= div_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    if (!is_div_q) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero_q) begin
                        hi <= dividend_q;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table of single ops plus
// hand-written stall/hold and mid-operation reset sequences.
module tb_muldiv_sequencer;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MFHI = 3'b100, MFLO = 3'b101, MTHI = 3'b110, MTLO = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .stall    (stall),
        .busy     (busy),
        .mf_data  (mf_data),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op, then counts busy cycles and checks the results.
    task automatic run_op(input vec_t v);
        int n;
        logic stall_bad;
        op_valid = 1'b1;
        op       = v.op;
        rs_data  = v.a;
        rt_data  = v.b;
        #1;
        check({v.name, " stall@accept"}, {31'b0, stall}, 32'd0);
        tick();
        op_valid = 1'b0;
        rs_data  = 32'hdead_beef;
        rt_data  = 32'h0bad_f00d;
        #1;
        n = 0;
        stall_bad = 1'b0;
        while (busy && n < 100) begin
            if (stall) stall_bad = 1'b1;
            n++;
            tick();
            #1;
        end
        check({v.name, " busy cycles"}, n, v.cycles);
        check({v.name, " stall w/o op"}, {31'b0, stall_bad}, 32'd0);
        check({v.name, " hi"}, hi, v.hi);
        check({v.name, " lo"}, lo, v.lo);
    endtask

    initial begin
        int n;
        int stall_cnt;

        vecs[0]  = '{"MULT 7*-3",        MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vecs[1]  = '{"MULTU max*max",    MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[2]  = '{"DIV -7/2",         DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{"DIVU 7/2",         DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        33};
        vecs[4]  = '{"DIVU 100/0",       DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 33};
        vecs[5]  = '{"DIV MIN/-1",       DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
        vecs[6]  = '{"DIV 7/-2",         DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[7]  = '{"MULT -5*-4",       MULT,  32'hFFFFFFFB, 32'hFFFFFFFC, 32'd0,        32'd20,       33};
        vecs[8]  = '{"MULT MIN*MIN",     MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        33};
        vecs[9]  = '{"DIV -8/0",         DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 33};
        vecs[10] = '{"DIVU max/16",      DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 33};
        vecs[11] = '{"MULTU x*16",       MULTU, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 33};
        vecs[12] = '{"MTHI",             MTHI,  32'h1234,     32'h0,        32'h1234,     32'h23456780, 0};
        vecs[13] = '{"MTLO",             MTLO,  32'h5678,     32'h0,        32'h1234,     32'h5678,     0};
        vecs[14] = '{"DIV -7/-2",        DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33};

        reset    = 1'b1;
        op_valid = 1'b0;
        op       = MFHI;
        rs_data  = '0;
        rt_data  = '0;
        tick();
        tick();
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset mf_data", mf_data, 32'd0);
        reset = 1'b0;
        tick();
        #1;

        for (int i = 0; i < 15; i++) run_op(vecs[i]);

        // MULT 6*7 with MFLO held from the 5th busy cycle.
        op_valid = 1'b1;
        op       = MULT;
        rs_data  = 32'd6;
        rt_data  = 32'd7;
        tick();
        op_valid = 1'b0;
        n = 1;
        stall_cnt = 0;
        #1;
        while (busy && n < 100) begin
            if (n == 5) begin
                op_valid = 1'b1;
                op       = MFLO;
                #1;
            end
            if (stall) stall_cnt++;
            n++;
            tick();
            #1;
        end
        check("hold stall cycles", stall_cnt, 29);
        check("hold stall released", {31'b0, stall}, 32'd0);
        check("hold mf_data", mf_data, 32'd42);
        tick();
        op_valid = 1'b0;
        #1;
        check("mf_data idle", mf_data, 32'd0);

        // Reset in the 10th cycle of a DIV.
        op_valid = 1'b1;
        op       = DIV;
        rs_data  = 32'd100;
        rt_data  = 32'd7;
        tick();
        op_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("div busy before reset", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        tick();
        #1;
        check("abort stays idle", {31'b0, busy}, 32'd0);

        op_valid = 1'b1;
        op       = MTHI;
        rs_data  = 32'd5;
        #1;
        check("MTHI stall", {31'b0, stall}, 32'd0);
        check("MTHI mf_data", mf_data, 32'd0);
        tick();
        op = MFHI;
        #1;
        check("MFHI stall", {31'b0, stall}, 32'd0);
        check("MFHI mf_data", mf_data, 32'd5);
        tick();
        op_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
